// File: rtl/debounce11_q.sv
`default_nettype none
// ============================================================================
//  Module      : debounce11_q
//  Description : Eleven-channel input qualifier for the NAND11 macro inputs
//                A0..A10. Each raw input is brought into the CK domain by a
//                two-flop synchroniser and then filtered. A channel's output
//                follows a new level only after that level has persisted for
//                FILT_CYC clock-enabled cycles. The filtered vector Q is
//                registered, together with a one-cycle change strobe CHG and
//                an all-high flag ALLHI (the complement of the downstream
//                NAND output).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     number of channels (11 for the NAND11 pairing)
//    FILT_CYC  enabled cycles a new level must persist before Q follows
//              (1 .. 2**CW)
//    CW        per-channel stability counter width (2**CW >= FILT_CYC)
//  Ports
//    CK     in   1      clock, rising edge
//    CD     in   1      asynchronous clear, active high
//    CE     in   1      clock enable for filter counters and outputs
//    D      in   WIDTH  raw asynchronous inputs
//    Q      out  WIDTH  filtered, registered levels (to NAND11 A0..A10)
//    CHG    out  1      one-cycle pulse: at least one Q bit changed
//    ALLHI  out  1      registered &Q, updated on the same edge as Q
// ============================================================================
module debounce11_q #(
  parameter int WIDTH    = 11,
  parameter int FILT_CYC = 4,
  parameter int CW       = 3
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CHG,
  output logic             ALLHI
);

  // Terminal count: the FILT_CYC-th consecutive mismatching enabled edge is
  // the one that lets Q follow, so the counter only ever reaches FILT_CYC-1.
  localparam logic [CW-1:0] c_last_cnt = CW'(FILT_CYC - 1);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser. Runs on every edge independent of CE so that the
  // filter always sees a settled view of D the moment CE is raised.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= D;
      r_s2 <= r_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers and the combinational next value of Q.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             r_chg;
  logic             r_allhi;

  // --------------------------------------------------------------------------
  // Per-channel stability filter. Each channel owns its counter; channels
  // never interact, so several may qualify on the same edge.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_differs;
    logic          w_expired;

    // Synchronised level disagrees with the currently published level.
    assign w_differs = r_s2[gi] ^ r_q[gi];

    // The disagreement has persisted long enough on this edge.
    assign w_expired = (r_cnt == c_last_cnt);

    // Q takes the new level only when the disagreement has lasted the full
    // filter window; otherwise it holds.
    assign w_q_next[gi] = (w_differs && w_expired) ? r_s2[gi] : r_q[gi];

    // Any return to Q's level restarts the window from zero, which is what
    // rejects glitches shorter than FILT_CYC. Qualifying also clears the
    // counter, so it never runs past FILT_CYC-1 and never wraps.
    assign w_cnt_next = (!w_differs || w_expired) ? '0 : (r_cnt + CW'(1));

    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        r_cnt <= '0;
      end else if (CE) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Q, CHG and ALLHI are registered together. ALLHI is derived from the next
  // Q value rather than the current one so it is never a cycle behind Q.
  // CHG is forced low on disabled cycles so it is a strict one-cycle pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      r_q     <= '0;
      r_chg   <= 1'b0;
      r_allhi <= 1'b0;
    end else if (CE) begin
      r_q     <= w_q_next;
      r_chg   <= (w_q_next != r_q);
      r_allhi <= &w_q_next;
    end else begin
      r_chg   <= 1'b0;
    end
  end

  assign Q     = r_q;
  assign CHG   = r_chg;
  assign ALLHI = r_allhi;

endmodule
`default_nettype wire

// File: tb/tb_debounce11_q.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce11_q
//  Description : Directed self-checking bench for debounce11_q. Expected
//                outputs are pushed to a scoreboard queue as each step is
//                driven and popped for comparison once the DUT has clocked.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce11_q;

  logic        CK;
  logic        CD;
  logic        CE;
  logic [10:0] D;
  logic [10:0] Q;
  logic        CHG;
  logic        ALLHI;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [10:0] q;
    logic        chg;
    logic        allhi;
  } exp_t;

  exp_t sb[$];

  debounce11_q #(
    .WIDTH    (11),
    .FILT_CYC (4),
    .CW       (3)
  ) u_dut (
    .CK    (CK),
    .CD    (CD),
    .CE    (CE),
    .D     (D),
    .Q     (Q),
    .CHG   (CHG),
    .ALLHI (ALLHI)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic push_exp(input string tag, input logic [10:0] eq,
                          input logic echg, input logic eall);
    exp_t e;
    e.tag   = tag;
    e.q     = eq;
    e.chg   = echg;
    e.allhi = eall;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end else begin
      e = sb.pop_front();
      total++;
      assert (Q === e.q) else begin
        bad++;
        $error("FAIL %s Q observed=%h expected=%h", e.tag, Q, e.q);
      end
      total++;
      assert (CHG === e.chg) else begin
        bad++;
        $error("FAIL %s CHG observed=%b expected=%b", e.tag, CHG, e.chg);
      end
      total++;
      assert (ALLHI === e.allhi) else begin
        bad++;
        $error("FAIL %s ALLHI observed=%b expected=%b", e.tag, ALLHI, e.allhi);
      end
    end
  endtask

  // One rising edge, checked 1 time unit after it.
  task automatic edge_chk(input string tag, input logic [10:0] eq,
                          input logic echg, input logic eall);
    push_exp(tag, eq, echg, eall);
    @(posedge CK);
    #1;
    pop_cmp();
  endtask

  task automatic run_chk(input int n, input string tag, input logic [10:0] eq,
                         input logic echg, input logic eall);
    for (int i = 0; i < n; i++) edge_chk(tag, eq, echg, eall);
  endtask

  // Check without waiting for a clock edge (asynchronous behaviour).
  task automatic now_chk(input string tag, input logic [10:0] eq,
                         input logic echg, input logic eall);
    push_exp(tag, eq, echg, eall);
    #1;
    pop_cmp();
  endtask

  initial begin
    CD = 1'b1;
    CE = 1'b1;
    D  = 11'h7FF;

    // ---- 1. reset holds everything low, then release with D all ones
    #1;
    now_chk("rst_async", 11'h000, 1'b0, 1'b0);
    run_chk(4, "rst_hold", 11'h000, 1'b0, 1'b0);
    CD = 1'b0;
    run_chk(5, "rst_rel_wait", 11'h000, 1'b0, 1'b0);
    edge_chk("rst_rel_q", 11'h7FF, 1'b1, 1'b1);
    edge_chk("rst_rel_after", 11'h7FF, 1'b0, 1'b1);

    // ---- 2. latency of a single bit
    CD = 1'b1;
    D  = 11'h000;
    now_chk("lat_clear", 11'h000, 1'b0, 1'b0);
    edge_chk("lat_clear_edge", 11'h000, 1'b0, 1'b0);
    CD = 1'b0;
    run_chk(3, "lat_settle", 11'h000, 1'b0, 1'b0);
    D = 11'h008;
    run_chk(5, "lat_wait", 11'h000, 1'b0, 1'b0);
    edge_chk("lat_q", 11'h008, 1'b1, 1'b0);
    run_chk(2, "lat_after", 11'h008, 1'b0, 1'b0);

    // ---- 3. glitch rejection on bit 7
    D = 11'h088;
    run_chk(3, "glitch3_hi", 11'h008, 1'b0, 1'b0);
    D = 11'h008;
    run_chk(8, "glitch3_rej", 11'h008, 1'b0, 1'b0);
    D = 11'h088;
    run_chk(4, "glitch4_hi", 11'h008, 1'b0, 1'b0);
    D = 11'h008;
    edge_chk("glitch4_wait", 11'h008, 1'b0, 1'b0);
    edge_chk("glitch4_rise", 11'h088, 1'b1, 1'b0);
    run_chk(3, "glitch4_held", 11'h088, 1'b0, 1'b0);
    edge_chk("glitch4_fall", 11'h008, 1'b1, 1'b0);
    edge_chk("glitch4_done", 11'h008, 1'b0, 1'b0);

    // ---- 4. CE gating, including a partial count held across CE low
    CD = 1'b1;
    D  = 11'h000;
    #1;
    CD = 1'b0;
    run_chk(3, "ce_settle", 11'h000, 1'b0, 1'b0);
    CE = 1'b0;
    D  = 11'h7FF;
    run_chk(10, "ce_low", 11'h000, 1'b0, 1'b0);
    CE = 1'b1;
    run_chk(3, "ce_count", 11'h000, 1'b0, 1'b0);
    edge_chk("ce_q", 11'h7FF, 1'b1, 1'b1);
    edge_chk("ce_after", 11'h7FF, 1'b0, 1'b1);
    D = 11'h000;
    run_chk(4, "ce_part", 11'h7FF, 1'b0, 1'b1);
    CE = 1'b0;
    run_chk(5, "ce_part_hold", 11'h7FF, 1'b0, 1'b1);
    CE = 1'b1;
    edge_chk("ce_part_resume", 11'h7FF, 1'b0, 1'b1);
    edge_chk("ce_part_q", 11'h000, 1'b1, 1'b0);
    edge_chk("ce_part_after", 11'h000, 1'b0, 1'b0);

    // ---- 5. simultaneous multi-bit change, then ALLHI alignment
    D = 11'h555;
    run_chk(5, "sim_wait", 11'h000, 1'b0, 1'b0);
    edge_chk("sim_q", 11'h555, 1'b1, 1'b0);
    edge_chk("sim_after", 11'h555, 1'b0, 1'b0);
    D = 11'h7FF;
    run_chk(5, "allhi_wait", 11'h555, 1'b0, 1'b0);
    edge_chk("allhi_q", 11'h7FF, 1'b1, 1'b1);

    // ---- 6. asynchronous clear mid-filter
    CD = 1'b1;
    D  = 11'h000;
    now_chk("mid_async", 11'h000, 1'b0, 1'b0);
    CD = 1'b0;
    run_chk(3, "mid_settle", 11'h000, 1'b0, 1'b0);
    D = 11'h001;
    run_chk(4, "mid_partial", 11'h000, 1'b0, 1'b0);
    CD = 1'b1;
    edge_chk("mid_in_rst", 11'h000, 1'b0, 1'b0);
    CD = 1'b0;
    run_chk(5, "mid_restart", 11'h000, 1'b0, 1'b0);
    edge_chk("mid_q", 11'h001, 1'b1, 1'b0);
    edge_chk("mid_after", 11'h001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
